// File: rtl/whack_game_core.sv
// N-hole whack-a-zombie engine: LFSR target selection, rising-edge hit scoring,
// per-target and per-round tick timers, saturating score/miss counters.
module whack_game_core #(
    parameter int unsigned N_HOLES    = 3,
    parameter int unsigned GAME_TICKS = 30,
    parameter int unsigned SHOW_TICKS = 4,
    parameter int unsigned SCORE_W    = 8,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              tick,
    input  logic                              start,
    input  logic [N_HOLES-1:0]                btn,
    output logic [N_HOLES-1:0]                led,
    output logic [SCORE_W-1:0]                score,
    output logic [SCORE_W-1:0]                misses,
    output logic [$clog2(GAME_TICKS+1)-1:0]   time_left,
    output logic                              gameover
);
    localparam int unsigned TW  = $clog2(N_HOLES);
    localparam int unsigned TLW = $clog2(GAME_TICKS + 1);
    localparam int unsigned SW  = $clog2(SHOW_TICKS + 1);
    localparam logic [N_HOLES-1:0] ONE = {{(N_HOLES-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {S_IDLE, S_SPAWN, S_SHOW, S_OVER} state_t;

    state_t              r_state;
    logic [15:0]         r_lfsr;
    logic [N_HOLES-1:0]  r_btn_q;
    logic [TW-1:0]       r_target;
    logic [SW-1:0]       r_show_cnt;

    logic [15:0]         w_lfsr_next;
    logic [TW-1:0]       w_cand;
    logic [TW-1:0]       w_next_tgt;
    logic [N_HOLES-1:0]  w_next_oh;
    logic [N_HOLES-1:0]  w_tgt_oh;
    logic [N_HOLES-1:0]  w_rise;
    logic                w_hit;
    logic                w_wrong;
    logic                w_show_to;
    logic                w_expire;
    logic [1:0]          w_miss_inc;

    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] v,
                                                   input logic [1:0] inc);
        logic [SCORE_W:0] s;
        s = {1'b0, v} + {{(SCORE_W-1){1'b0}}, inc};
        return s[SCORE_W] ? '1 : s[SCORE_W-1:0];
    endfunction

    always_comb begin
        w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
        w_cand      = TW'(r_lfsr[7:0] % 8'(N_HOLES));
        // Bump a repeated candidate to the next hole so targets never repeat.
        if (w_cand == r_target)
            w_next_tgt = (w_cand == TW'(N_HOLES - 1)) ? '0 : w_cand + TW'(1);
        else
            w_next_tgt = w_cand;
        w_next_oh  = ONE << w_next_tgt;
        w_tgt_oh   = ONE << r_target;
        w_rise     = btn & ~r_btn_q;
        w_hit      = (w_rise == w_tgt_oh);
        w_wrong    = |(w_rise & ~w_tgt_oh);
        w_show_to  = tick && (r_show_cnt == SW'(1));
        w_expire   = tick && (time_left == TLW'(1));
        w_miss_inc = {1'b0, w_wrong} + {1'b0, w_show_to};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_lfsr     <= LFSR_SEED;
            r_btn_q    <= '0;
            r_target   <= '0;
            r_show_cnt <= '0;
            led        <= '0;
            score      <= '0;
            misses     <= '0;
            time_left  <= '0;
            gameover   <= 1'b0;
        end else begin
            r_lfsr  <= w_lfsr_next;
            r_btn_q <= btn;
            // start behaves identically in every state: fresh round from SPAWN.
            if (start) begin
                score     <= '0;
                misses    <= '0;
                time_left <= TLW'(GAME_TICKS);
                gameover  <= 1'b0;
                led       <= '0;
                r_state   <= S_SPAWN;
            end else begin
                case (r_state)
                    S_IDLE, S_OVER: led <= '0;
                    S_SPAWN: begin
                        r_target   <= w_next_tgt;
                        r_show_cnt <= SW'(SHOW_TICKS);
                        if (tick)
                            time_left <= time_left - TLW'(1);
                        if (w_expire) begin
                            r_state  <= S_OVER;
                            gameover <= 1'b1;
                            led      <= '0;
                        end else begin
                            led     <= w_next_oh;
                            r_state <= S_SHOW;
                        end
                    end
                    S_SHOW: begin
                        if (tick) begin
                            time_left  <= time_left - TLW'(1);
                            r_show_cnt <= r_show_cnt - SW'(1);
                        end
                        if (w_hit) begin
                            score   <= sat_add(score, 2'd1);
                            led     <= '0;
                            r_state <= S_SPAWN;
                        end else begin
                            misses <= sat_add(misses, w_miss_inc);
                            if (w_show_to) begin
                                led     <= '0;
                                r_state <= S_SPAWN;
                            end
                        end
                        if (w_expire) begin
                            r_state  <= S_OVER;
                            gameover <= 1'b1;
                            led      <= '0;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_whack_game_core.sv
// Directed bench for whack_game_core: default 3-hole core plus a 5-hole
// instance exercising long spawn sequences.
module tb_whack_game_core;
    logic        clk = 1'b0;
    logic        rst, tick, start;
    logic [2:0]  btn, led;
    logic [7:0]  score, misses;
    logic [4:0]  time_left;
    logic        gameover;

    logic        tick2, start2;
    logic [4:0]  btn2, led2;
    logic [7:0]  score2, misses2;
    logic [11:0] time_left2;
    logic        gameover2;

    int tests = 0;
    int fails = 0;
    int nstep = 0;
    bit tick_en = 1'b1;

    logic [2:0] lit, wrong;
    logic [4:0] prev2;
    int         spawns;

    always #5 clk = ~clk;

    whack_game_core #(
        .N_HOLES(3), .GAME_TICKS(30), .SHOW_TICKS(4), .SCORE_W(8), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .btn(btn), .led(led),
        .score(score), .misses(misses), .time_left(time_left), .gameover(gameover)
    );

    whack_game_core #(
        .N_HOLES(5), .GAME_TICKS(4000), .SHOW_TICKS(1), .SCORE_W(8), .LFSR_SEED(16'hACE1)
    ) dut5 (
        .clk(clk), .rst(rst), .tick(tick2), .start(start2), .btn(btn2), .led(led2),
        .score(score2), .misses(misses2), .time_left(time_left2), .gameover(gameover2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Every 10th step of a round carries a tick.
    task automatic step();
        tick = tick_en && (((nstep + 1) % 10) == 0);
        @(posedge clk);
        #1;
        nstep++;
        tick = 1'b0;
    endtask

    task automatic run_to(input int n);
        while (nstep < n) step();
    endtask

    task automatic start_round();
        start = 1'b1;
        nstep = 0;
        step();
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; start = 1'b0; btn = '0;
        tick2 = 1'b0; start2 = 1'b0; btn2 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_led", led, 0);
        check("rst_score", score, 0);
        check("rst_misses", misses, 0);
        check("rst_time", time_left, 0);
        check("rst_gameover", gameover, 0);
        rst = 1'b0;
        step(); step();
        check("idle_led", led, 0);

        // round start, first target
        start_round();
        check("t1_time", time_left, 30);
        check("t1_score", score, 0);
        check("t1_gameover", gameover, 0);
        step();
        check("t1_onehot", 32'($onehot(led)), 1);
        lit = led;

        // correct hit
        btn = lit; step();
        check("t2_score", score, 1);
        check("t2_led_off", led, 0);
        btn = '0; step();
        check("t2_onehot", 32'($onehot(led)), 1);
        check("t2_norepeat", 32'(led != lit), 1);
        lit = led;

        // wrong hole, then target+wrong together
        wrong = {lit[1:0], lit[2]};
        btn = wrong; step(); btn = '0; step();
        check("t3_miss1", misses, 1);
        btn = lit | wrong; step(); btn = '0; step();
        check("t3_miss2", misses, 2);
        check("t3_score", score, 1);
        check("t3_led_held", led, 32'(lit));

        // target timeout after 4 ticks (ticks at steps 10,20,30,40)
        run_to(39);
        check("t4_pre_miss", misses, 2);
        check("t4_pre_led", led, 32'(lit));
        check("t4_pre_time", time_left, 27);
        run_to(40);
        check("t4_to_miss", misses, 3);
        check("t4_to_led", led, 0);
        check("t4_to_time", time_left, 26);
        run_to(41);
        check("t4_onehot", 32'($onehot(led)), 1);
        check("t4_norepeat", 32'(led != lit), 1);
        lit = led;
        btn = lit;
        run_to(42);
        check("t4_hold_hit", score, 2);
        run_to(61);
        check("t4_hold_score", score, 2);
        check("t4_hold_miss", misses, 3);
        btn = '0;

        // round expiry; timeouts at 80,120,...,280 add six misses
        run_to(299);
        check("t5_time1", time_left, 1);
        check("t5_not_over", gameover, 0);
        check("t5_miss_pre", misses, 9);
        run_to(300);
        check("t5_gameover", gameover, 1);
        check("t5_led", led, 0);
        check("t5_time0", time_left, 0);
        check("t5_score", score, 2);
        check("t5_miss", misses, 9);
        btn = 3'b111; step(); btn = '0; step(); step();
        check("t5_frz_score", score, 2);
        check("t5_frz_miss", misses, 9);
        check("t5_frz_over", gameover, 1);
        check("t5_frz_led", led, 0);
        start_round();
        check("t5_rs_over", gameover, 0);
        check("t5_rs_score", score, 0);
        check("t5_rs_miss", misses, 0);
        check("t5_rs_time", time_left, 30);

        // saturation with the round timer frozen
        tick_en = 1'b0;
        step();
        for (int k = 1; k <= 300; k++) begin
            int g;
            g = 0;
            while (led == '0 && g < 5) begin
                step();
                g++;
            end
            if (led == '0) begin
                check("t6_led_lit", 0, 1);
                break;
            end
            btn = led; step(); btn = '0;
            if (k == 1)   check("t6_score1", score, 1);
            if (k == 254) check("t6_score254", score, 254);
            if (k == 255) check("t6_score255", score, 255);
            if (k == 256) check("t6_sat256", score, 255);
            if (k == 300) check("t6_sat300", score, 255);
            step();
        end
        check("t6_miss", misses, 0);
        check("t6_time", time_left, 30);
        check("t6_show_lit", 32'($onehot(led)), 1);

        // asynchronous reset in the middle of SHOW
        rst = 1'b1;
        #2;
        check("t6_rst_led", led, 0);
        check("t6_rst_score", score, 0);
        check("t6_rst_miss", misses, 0);
        check("t6_rst_time", time_left, 0);
        check("t6_rst_over", gameover, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        step();
        check("t6_post_idle", led, 0);

        // five holes, 1000 spawns
        start2 = 1'b1; step(); start2 = 1'b0;
        tick2 = 1'b1;
        spawns = 0;
        prev2 = '0;
        for (int i = 0; i < 2400 && spawns < 1000; i++) begin
            step();
            if (led2 != '0) begin
                spawns++;
                check("n5_onehot", 32'($onehot(led2)), 1);
                if (spawns > 1) check("n5_norepeat", 32'(led2 != prev2), 1);
                prev2 = led2;
            end
        end
        tick2 = 1'b0;
        check("n5_spawns", spawns, 1000);
        check("n5_score", score2, 0);
        check("n5_misses", misses2, 255);
        check("n5_time", time_left2, 2001);
        check("n5_over", gameover2, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
